// File: rtl/mem_responder.sv
// mem_responder: 256x8 request/response memory with programmable wait states,
// write-through response data, a completed-access counter and a debug preload port.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  output logic       ready,
  output logic       busy,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       load_ack,
  output logic [7:0] acc_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       r_is_wr;
  logic [7:0] r_q;
  logic       r_ready;
  logic       r_busy;
  logic       r_load_ack;
  logic [7:0] r_acc;

  // Power-up contents only; reset deliberately leaves the array alone.
  logic [7:0] r_mem [256] = '{default: (INIT_ZERO ? 8'h00 : 8'hxx)};

  logic       w_req;
  logic       w_load;
  logic       w_commit;
  logic       w_mem_we;
  logic [7:0] w_mem_addr;
  logic [7:0] w_mem_wdata;

  assign w_req    = MemRead | wren;
  // A request in the same idle cycle takes priority and the preload is dropped.
  assign w_load   = reset & (r_state == IDLE) & load_en & ~w_req;
  assign w_commit = (r_state == RESP) & r_is_wr;

  always_comb begin
    w_mem_we    = w_load | w_commit;
    w_mem_addr  = load_addr;
    w_mem_wdata = load_data;
    if (w_commit) begin
      w_mem_addr  = r_addr;
      w_mem_wdata = r_data;
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_is_wr    <= 1'b0;
      r_q        <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_load_ack <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_ready    <= 1'b0;
      r_load_ack <= w_load;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= address;
            r_data  <= data;
            r_is_wr <= wren;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == LAST_WAIT) begin
            r_cnt   <= '0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          r_q     <= r_is_wr ? r_data : r_mem[r_addr];
          r_ready <= 1'b1;
          r_acc   <= r_acc + 8'd1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign q         = r_q;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign load_ack  = r_load_ack;
  assign acc_count = r_acc;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 3 and 5 wait cycles) share one
// stimulus stream and are each checked every cycle against a countdown model.
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       MemRead = 1'b0;
  logic       wren = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] data = 8'h00;
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00;
  logic [7:0] load_data = 8'h00;

  logic [7:0] q_w   [3];
  logic       rdy_w [3];
  logic       bsy_w [3];
  logic       ack_w [3];
  logic [7:0] acc_w [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clock = ~clock;

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
    .address(address), .data(data), .q(q_w[0]), .ready(rdy_w[0]), .busy(bsy_w[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ack(ack_w[0]), .acc_count(acc_w[0]));

  mem_responder #(.WAIT_CYCLES(3)) u_dut1 (
    .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
    .address(address), .data(data), .q(q_w[1]), .ready(rdy_w[1]), .busy(bsy_w[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ack(ack_w[1]), .acc_count(acc_w[1]));

  mem_responder #(.WAIT_CYCLES(5)) u_dut2 (
    .clock(clock), .reset(reset), .MemRead(MemRead), .wren(wren),
    .address(address), .data(data), .q(q_w[2]), .ready(rdy_w[2]), .busy(bsy_w[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ack(ack_w[2]), .acc_count(acc_w[2]));

  function automatic int wc(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // Model: a transaction is "remaining cycles until response"; zero means idle.
  int         rem   [3] = '{0, 0, 0};
  logic [7:0] la    [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] ld    [3] = '{8'h00, 8'h00, 8'h00};
  logic       lwr   [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] mq    [3] = '{8'h00, 8'h00, 8'h00};
  logic       mrdy  [3] = '{1'b0, 1'b0, 1'b0};
  logic       mbsy  [3] = '{1'b0, 1'b0, 1'b0};
  logic       mack  [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] macc  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] mmem  [3][256] = '{default: '{default: 8'h00}};

  initial forever begin
    @(posedge clock or negedge reset);
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        rem[i] = 0; mq[i] = 8'h00; mrdy[i] = 1'b0; mbsy[i] = 1'b0;
        mack[i] = 1'b0; macc[i] = 8'h00;
      end else begin
        mrdy[i] = 1'b0;
        mack[i] = 1'b0;
        if (rem[i] == 0) begin
          if (MemRead || wren) begin
            la[i] = address; ld[i] = data; lwr[i] = wren;
            rem[i] = wc(i) + 1;
            mbsy[i] = 1'b1;
          end else if (load_en) begin
            mmem[i][load_addr] = load_data;
            mack[i] = 1'b1;
          end
        end else begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) begin
            if (lwr[i]) begin
              mmem[i][la[i]] = ld[i];
              mq[i] = ld[i];
            end else begin
              mq[i] = mmem[i][la[i]];
            end
            mrdy[i] = 1'b1;
            macc[i] = macc[i] + 8'd1;
            mbsy[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %02h expected %02h at %0t", name, idx, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        cmp("q", i, q_w[i], mq[i]);
        cmp("ready", i, {7'd0, rdy_w[i]}, {7'd0, mrdy[i]});
        cmp("busy", i, {7'd0, bsy_w[i]}, {7'd0, mbsy[i]});
        cmp("load_ack", i, {7'd0, ack_w[i]}, {7'd0, mack[i]});
        cmp("acc_count", i, acc_w[i], macc[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    MemRead = 1'b0; wren = 1'b0; load_en = 1'b0;
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'($urandom_range(0, 7));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    idle();
    repeat (3) tick();
    cmp("rst_q", 0, q_w[0], 8'h00);
    cmp("rst_busy", 0, {7'd0, bsy_w[0]}, 8'h00);
    cmp("rst_acc", 0, acc_w[0], 8'h00);
    chk_en = 1'b1;
    reset = 1'b1;

    // Preload then read on the first edges after reset release.
    load_en = 1'b1; load_addr = 8'h10; load_data = 8'hA5; tick(); idle();
    cmp("pre_ack", 0, {7'd0, ack_w[0]}, 8'h01);
    MemRead = 1'b1; address = 8'h10; tick(); idle();
    cmp("w0_busy", 0, {7'd0, bsy_w[0]}, 8'h01);
    tick();
    cmp("w0_ready", 0, {7'd0, rdy_w[0]}, 8'h01);
    cmp("w0_q", 0, q_w[0], 8'hA5);
    cmp("w0_acc", 0, acc_w[0], 8'h01);
    repeat (8) tick();

    // Write at 0xFF with three wait cycles.
    wren = 1'b1; address = 8'hFF; data = 8'h3C; tick(); idle();
    for (int k = 0; k < 4; k++) begin
      cmp("w3_busy", 1, {7'd0, bsy_w[1]}, 8'h01);
      cmp("w3_noready", 1, {7'd0, rdy_w[1]}, 8'h00);
      tick();
    end
    cmp("w3_ready", 1, {7'd0, rdy_w[1]}, 8'h01);
    cmp("w3_q", 1, q_w[1], 8'h3C);
    cmp("w3_idle", 1, {7'd0, bsy_w[1]}, 8'h00);
    repeat (8) tick();
    MemRead = 1'b1; address = 8'hFF; tick(); idle();
    repeat (4) tick();
    cmp("w3_rdback", 1, q_w[1], 8'h3C);
    repeat (8) tick();

    // Simultaneous read and write behaves as a write.
    MemRead = 1'b1; wren = 1'b1; address = 8'h00; data = 8'h77; tick(); idle();
    tick();
    cmp("both_q", 0, q_w[0], 8'h77);
    repeat (8) tick();
    MemRead = 1'b1; address = 8'h00; tick(); idle(); tick();
    cmp("both_rdback", 0, q_w[0], 8'h77);
    repeat (8) tick();

    // Preload colliding with a request is dropped.
    load_en = 1'b1; load_addr = 8'h40; load_data = 8'h5A; tick(); idle();
    repeat (2) tick();
    MemRead = 1'b1; address = 8'h10; load_en = 1'b1; load_addr = 8'h40; load_data = 8'hEE;
    tick(); idle();
    cmp("coll_ack", 0, {7'd0, ack_w[0]}, 8'h00);
    tick();
    cmp("coll_q", 0, q_w[0], 8'hA5);
    repeat (8) tick();
    MemRead = 1'b1; address = 8'h40; tick(); idle(); tick();
    cmp("coll_keep", 0, q_w[0], 8'h5A);
    repeat (8) tick();

    // Reset during the wait phase aborts the pending write.
    load_en = 1'b1; load_addr = 8'h20; load_data = 8'h99; tick(); idle();
    repeat (2) tick();
    wren = 1'b1; address = 8'h20; data = 8'h11; tick(); idle();
    repeat (2) tick();
    cmp("abort_busy", 2, {7'd0, bsy_w[2]}, 8'h01);
    reset = 1'b0;
    #1;
    cmp("abort_q", 2, q_w[2], 8'h00);
    cmp("abort_idle", 2, {7'd0, bsy_w[2]}, 8'h00);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    MemRead = 1'b1; address = 8'h20; tick(); idle();
    repeat (6) tick();
    cmp("abort_old", 2, q_w[2], 8'h99);
    repeat (8) tick();

    // 256 completed reads wrap the access counter.
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      MemRead = 1'b1; address = 8'(i); tick(); idle(); tick();
      if (i == 254) cmp("acc_ff", 0, acc_w[0], 8'hFF);
    end
    cmp("acc_wrap", 0, acc_w[0], 8'h00);
    repeat (8) tick();

    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      MemRead   = ($urandom_range(0, 9) < 3);
      wren      = ($urandom_range(0, 9) < 3);
      load_en   = ($urandom_range(0, 9) < 3);
      address   = pick_addr();
      data      = 8'($urandom);
      load_addr = pick_addr();
      load_data = 8'($urandom);
      tick();
    end
    reset = 1'b1;
    idle();
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
